cmd_tx: RTL

- Transmit end of the robot command link: forms 8-bit command bytes and serializes them as 8N1 UART frames on TX.
- The receiving side's UART produces cmd/cmd_rdy from these frames; byte format is cmd[7:6] = opcode (2'b01 GO, 2'b00 STOP), cmd[5:0] = destination station ID.
- Sits in the remote/base-station design; driven by debounced button pulses and a 6-bit station-select value.

---
 rtl/cmd_tx.sv | 103 ++++++++++
 1 files changed

// File: rtl/cmd_tx.sv
// cmd_tx: forms GO/STOP command bytes and sends them as 8N1 UART frames on TX.
// Define CMD_TX_PARITY_EN to insert an even parity bit before the stop bit (11-bit frame).
module cmd_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_go,
  input  logic       send_stop,
  input  logic [5:0] dest_ID,
  output logic       TX,
  output logic       busy,
  output logic       tx_done,
  output logic [7:0] cmd_sent
);
  localparam logic [1:0] IDLE = 2'd0, XMIT = 2'd1, DONE = 2'd2;
`ifdef CMD_TX_PARITY_EN
  localparam int FW = 11;
  function automatic logic [FW-1:0] frame(input logic [7:0] b);
    return {1'b1, ^b, b, 1'b0};
  endfunction
`else
  localparam int FW = 10;
  function automatic logic [FW-1:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction
`endif
  localparam logic [3:0] LAST = 4'(FW - 1);
  localparam logic [12:0] TERM = 13'(BAUD_DIV - 1);
  logic [1:0] state_q, state_d;
  logic [FW-1:0] sh_q, sh_d;
  logic [12:0] baud_q, baud_d;
  logic [3:0] bit_q, bit_d;
  logic pend_q, pend_d;
  logic [7:0] byte_q, byte_d, sent_q, sent_d;
  logic tc;
  assign tc = baud_q == TERM;
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    baud_d = baud_q;
    bit_d = bit_q;
    pend_d = pend_q;
    byte_d = byte_q;
    sent_d = sent_q;
    case (state_q)
      IDLE: if (send_go | send_stop) begin
        byte_d = send_stop ? 8'h00 : {2'b01, dest_ID};
        sh_d = frame(byte_d);
        baud_d = '0;
        bit_d = '0;
        state_d = XMIT;
      end
      XMIT: begin
        pend_d = pend_q | send_stop;
        baud_d = tc ? 13'd0 : baud_q + 13'd1;
        if (tc) begin
          sh_d = {1'b1, sh_q[FW-1:1]};
          bit_d = bit_q + 4'd1;
          if (bit_q == LAST) begin
            state_d = DONE;
            sent_d = byte_q;
          end
        end
      end
      DONE: begin
        // a STOP arriving in the DONE cycle itself merges into the pending one
        state_d = (pend_q | send_stop) ? XMIT : IDLE;
        if (pend_q | send_stop) begin
          byte_d = 8'h00;
          sh_d = frame(8'h00);
          baud_d = '0;
          bit_d = '0;
          pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q <= '1;
      baud_q <= '0;
      bit_q <= '0;
      pend_q <= 1'b0;
      byte_q <= '0;
      sent_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      pend_q <= pend_d;
      byte_q <= byte_d;
      sent_q <= sent_d;
    end
  end
  assign TX = (state_q == XMIT) ? sh_q[0] : 1'b1;
  assign busy = state_q != IDLE;
  assign tx_done = state_q == DONE;
  assign cmd_sent = sent_q;
endmodule
